parking_access_ctrl: RTL and testbench

- Parking-lot access controller: accepts entry/exit requests, validates the access code, and pulses the barrier.
- Tracks occupied places and drives the occupancy display and full flag.
- Drives the barrier/display/full output interface consumed by the team's output monitor and assertions.
- Invariants: barrier is a one-cycle pulse; display 255 implies full.

---
 rtl/parking_access_ctrl_pkg.sv | 22 ++
 rtl/parking_access_ctrl_if.sv | 36 +++
 rtl/parking_access_ctrl_timer.sv | 34 +++
 rtl/parking_access_ctrl.sv | 140 ++++++++++++++
 tb/tb_parking_access_ctrl.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/parking_access_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// parking_pkg
// Shared types and default constants for the parking access controller.
//   state_e     : FSM state encoding (IDLE, WAIT_IN, WAIT_OUT)
//   count_t     : occupancy count type (8 bits)
//   DEF_*       : default CAPACITY / TIMEOUT / ACCESS_CODE
// -----------------------------------------------------------------------------
package parking_pkg;

    typedef logic [7:0] count_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_IN  = 2'd1,
        ST_WAIT_OUT = 2'd2
    } state_e;

    localparam int           DEF_CAPACITY    = 255;
    localparam int           DEF_TIMEOUT     = 16;
    localparam logic [7:0]   DEF_ACCESS_CODE = 8'hA5;

endpackage

// File: rtl/parking_access_ctrl_if.sv
// -----------------------------------------------------------------------------
// parking_access_ctrl_if
// Request / barrier / display bundle of the parking access controller.
//   Requests (master -> slave): cerere_intrare, cod_acces, cerere_iesire,
//                               senzor_trecere
//   Status   (slave -> master): bariera, acces_respins, afisare_locuri,
//                               parcare_full, dbg_state
// Handshake: there is no ready path. A request is taken on every rising
// edge where it is high while the controller is IDLE; exactly one of
// bariera / acces_respins answers it in the following cycle. Requests seen
// outside IDLE are dropped silently. dbg_state mirrors the FSM register.
// -----------------------------------------------------------------------------
interface parking_access_ctrl_if;
    import parking_pkg::*;

    logic        cerere_intrare;
    logic [7:0]  cod_acces;
    logic        cerere_iesire;
    logic        senzor_trecere;
    logic        bariera;
    logic        acces_respins;
    count_t      afisare_locuri;
    logic        parcare_full;
    logic [1:0]  dbg_state;

    modport master (
        output cerere_intrare, cod_acces, cerere_iesire, senzor_trecere,
        input  bariera, acces_respins, afisare_locuri, parcare_full, dbg_state
    );

    modport slave (
        input  cerere_intrare, cod_acces, cerere_iesire, senzor_trecere,
        output bariera, acces_respins, afisare_locuri, parcare_full, dbg_state
    );

endinterface

// File: rtl/parking_access_ctrl_timer.sv
// -----------------------------------------------------------------------------
// parking_timer
// Clear/enable up-counter used to bound the wait for the pass sensor.
//   clk, reset  : system clock, synchronous active-high reset
//   i_clear     : force the count to 0 (has priority over enable)
//   i_enable    : advance the count by one
//   o_expired   : count has reached TIMEOUT-1 (last wait cycle)
// -----------------------------------------------------------------------------
module parking_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    logic [7:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_cnt <= 8'd0;
        end else if (i_enable && (r_cnt != LAST)) begin
            // Holds at LAST so a late enable can never wrap the count.
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign o_expired = (r_cnt == LAST);

endmodule

// File: rtl/parking_access_ctrl.sv
// -----------------------------------------------------------------------------
// parking_access_ctrl
// Parking-lot access controller: serves entry/exit requests, pulses the
// barrier, waits for the car to pass and tracks occupancy.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : parking_access_ctrl_if.slave (requests in, barrier / reject
//                pulses, occupancy count, full flag, FSM state out)
// Build option: PARKING_ACCESS_CODE_EN -- when defined, entry also requires
// cod_acces == ACCESS_CODE; otherwise the code is ignored.
// -----------------------------------------------------------------------------
module parking_access_ctrl
    import parking_pkg::*;
#(
    parameter int         CAPACITY    = DEF_CAPACITY,
    parameter int         TIMEOUT     = DEF_TIMEOUT,
    parameter logic [7:0] ACCESS_CODE = DEF_ACCESS_CODE
) (
    input  logic                  clk,
    input  logic                  reset,
    parking_access_ctrl_if.slave  bus
);

    localparam logic [1:0] S_IDLE     = ST_IDLE;
    localparam logic [1:0] S_WAIT_IN  = ST_WAIT_IN;
    localparam logic [1:0] S_WAIT_OUT = ST_WAIT_OUT;
    localparam count_t     CAP        = count_t'(CAPACITY);

    logic [1:0] r_state;
    count_t     r_count;
    logic       r_full;
    logic       r_bariera;
    logic       r_respins;

    logic [1:0] w_next_state;
    count_t     w_next_count;
    logic       w_bariera;
    logic       w_respins;
    logic       w_timer_clear;
    logic       w_expired;
    logic       w_code_ok;

`ifdef PARKING_ACCESS_CODE_EN
    assign w_code_ok = (bus.cod_acces == ACCESS_CODE);
`else
    logic w_unused_code;
    assign w_unused_code = ^bus.cod_acces;
    assign w_code_ok     = 1'b1;
`endif

    // Timer restarts on the edge that opens the barrier, so it reads 0 in
    // the first WAIT cycle and runs only while a pass is pending.
    parking_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_timer_clear),
        .i_enable  (r_state != S_IDLE),
        .o_expired (w_expired)
    );

    always_comb begin
        w_next_state  = r_state;
        w_next_count  = r_count;
        w_bariera     = 1'b0;
        w_respins     = 1'b0;
        w_timer_clear = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Exit has priority; a simultaneous entry is dropped.
                if (bus.cerere_iesire) begin
                    if (r_count != '0) begin
                        w_bariera     = 1'b1;
                        w_timer_clear = 1'b1;
                        w_next_state  = S_WAIT_OUT;
                    end else begin
                        w_respins = 1'b1;
                    end
                end else if (bus.cerere_intrare) begin
                    if (w_code_ok && !r_full) begin
                        w_bariera     = 1'b1;
                        w_timer_clear = 1'b1;
                        w_next_state  = S_WAIT_IN;
                    end else begin
                        w_respins = 1'b1;
                    end
                end
            end
            S_WAIT_IN: begin
                // Sensor on the expiry edge still counts as a pass.
                if (bus.senzor_trecere) begin
                    if (r_count != CAP) begin
                        w_next_count = r_count + 8'd1;
                    end
                    w_next_state = S_IDLE;
                end else if (w_expired) begin
                    w_next_state = S_IDLE;
                end
            end
            S_WAIT_OUT: begin
                if (bus.senzor_trecere) begin
                    if (r_count != '0) begin
                        w_next_count = r_count - 8'd1;
                    end
                    w_next_state = S_IDLE;
                end else if (w_expired) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_full    <= 1'b0;
            r_bariera <= 1'b0;
            r_respins <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_count   <= w_next_count;
            // Full is computed from the next count so flag and count
            // always change on the same edge.
            r_full    <= (w_next_count == CAP);
            r_bariera <= w_bariera;
            r_respins <= w_respins;
        end
    end

    assign bus.bariera        = r_bariera;
    assign bus.acces_respins  = r_respins;
    assign bus.afisare_locuri = r_count;
    assign bus.parcare_full   = r_full;
    assign bus.dbg_state      = r_state;

endmodule

// File: tb/tb_parking_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_parking_access_ctrl
// Directed bench for parking_access_ctrl (CAPACITY 255, TIMEOUT 16).
// Every request pushes its expected response {bariera, acces_respins, count}
// into exp_q; the monitor pops one entry for each pulse the DUT presents.
// -----------------------------------------------------------------------------
module tb_parking_access_ctrl;

    logic clk;
    logic reset;

    parking_access_ctrl_if bus_if ();

    parking_access_ctrl #(
        .CAPACITY    (255),
        .TIMEOUT     (16),
        .ACCESS_CODE (8'hA5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    // ---------------- scoreboard state ----------------
    logic [9:0] exp_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         m_count = 0;
    logic       prev_bariera = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [9:0] got;
        logic [9:0] exp;
        got = {bus_if.bariera, bus_if.acces_respins, bus_if.afisare_locuri};
        if (bus_if.bariera || bus_if.acces_respins) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_pulse: got %0h, required no pulse (t=%0t)", got, $time);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    n_err++;
                    $display("FAIL response: got %0h, required %0h (t=%0t)", got, exp, $time);
                end
            end
        end
        if (prev_bariera && bus_if.bariera) begin
            n_vec++;
            n_err++;
            $display("FAIL barrier_width: got 2-cycle pulse, required 1 (t=%0t)", $time);
        end
        prev_bariera = bus_if.bariera;
        if (!reset && (bus_if.parcare_full !== (bus_if.afisare_locuri == 8'd255))) begin
            n_vec++;
            n_err++;
            $display("FAIL full_flag: got %0d with count %0d, required %0d (t=%0t)",
                     bus_if.parcare_full, bus_if.afisare_locuri,
                     (bus_if.afisare_locuri == 8'd255), $time);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic req(input bit ent, input bit ext, input logic [7:0] code,
                       input logic [9:0] exp);
        @(posedge clk); #1;
        bus_if.cerere_intrare = ent;
        bus_if.cerere_iesire  = ext;
        bus_if.cod_acces      = code;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        bus_if.cerere_intrare = 1'b0;
        bus_if.cerere_iesire  = 1'b0;
        bus_if.cod_acces      = 8'h00;
    endtask

    task automatic pass();
        @(posedge clk); #1;
        bus_if.senzor_trecere = 1'b1;
        @(posedge clk); #1;
        bus_if.senzor_trecere = 1'b0;
    endtask

    task automatic admit();
        req(1'b1, 1'b0, 8'hA5, {2'b10, 8'(m_count)});
        pass();
        m_count++;
    endtask

    task automatic leave();
        req(1'b0, 1'b1, 8'hA5, {2'b10, 8'(m_count)});
        pass();
        m_count--;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int waited;
        reset                 = 1'b1;
        bus_if.cerere_intrare = 1'b0;
        bus_if.cerere_iesire  = 1'b0;
        bus_if.cod_acces      = 8'h00;
        bus_if.senzor_trecere = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_bariera", bus_if.bariera, 0);
        check("rst_respins", bus_if.acces_respins, 0);
        check("rst_count", bus_if.afisare_locuri, 0);
        check("rst_full", bus_if.parcare_full, 0);
        check("rst_state", bus_if.dbg_state, 0);

        // Exit from an empty lot is refused.
        req(1'b0, 1'b1, 8'h00, {2'b01, 8'd0});
        check("empty_exit_state", bus_if.dbg_state, 0);

        // Entry with the valid code, sensor 3 cycles after the request.
        req(1'b1, 1'b0, 8'hA5, {2'b10, 8'd0});
        check("entry_state", bus_if.dbg_state, 1);
        @(posedge clk);
        pass();
        m_count = 1;
        check("entry_count", bus_if.afisare_locuri, 1);
        check("entry_full", bus_if.parcare_full, 0);
        check("entry_idle", bus_if.dbg_state, 0);

        // Entry with a wrong code.
`ifdef PARKING_ACCESS_CODE_EN
        req(1'b1, 1'b0, 8'h00, {2'b01, 8'(m_count)});
`else
        req(1'b1, 1'b0, 8'h00, {2'b10, 8'(m_count)});
        pass();
        m_count++;
`endif
        check("badcode_count", bus_if.afisare_locuri, 8'(m_count));

        // Simultaneous entry and exit at count 5: exit wins.
        while (m_count < 5) admit();
        req(1'b1, 1'b1, 8'hA5, {2'b10, 8'd5});
        check("simul_state", bus_if.dbg_state, 2);
        pass();
        m_count = 4;
        check("simul_count", bus_if.afisare_locuri, 4);
        check("simul_idle", bus_if.dbg_state, 0);
        repeat (3) @(posedge clk);

        // Entry without a pass: 16 WAIT cycles then IDLE, count unchanged.
        req(1'b1, 1'b0, 8'hA5, {2'b10, 8'd4});
        waited = 0;
        while (bus_if.dbg_state != 2'd0 && waited < 40) begin
            @(posedge clk); #1;
            waited++;
        end
        check("timeout_cycles", waited, 16);
        check("timeout_count", bus_if.afisare_locuri, 4);
        admit();
        check("after_timeout_count", bus_if.afisare_locuri, 5);

        // Sensor on the last WAIT edge still counts.
        req(1'b1, 1'b0, 8'hA5, {2'b10, 8'd5});
        repeat (15) @(posedge clk);
        #1 bus_if.senzor_trecere = 1'b1;
        @(posedge clk); #1 bus_if.senzor_trecere = 1'b0;
        m_count = 6;
        check("lastedge_count", bus_if.afisare_locuri, 6);
        check("lastedge_idle", bus_if.dbg_state, 0);

        // Requests during WAIT are ignored with no reject.
        req(1'b1, 1'b0, 8'hA5, {2'b10, 8'd6});
        @(posedge clk); #1;
        bus_if.cerere_intrare = 1'b1;
        bus_if.cerere_iesire  = 1'b1;
        bus_if.cod_acces      = 8'hA5;
        @(posedge clk); #1;
        bus_if.cerere_intrare = 1'b0;
        bus_if.cerere_iesire  = 1'b0;
        bus_if.cod_acces      = 8'h00;
        pass();
        m_count = 7;
        check("wait_ignore_count", bus_if.afisare_locuri, 7);

        // Sensor in IDLE is ignored.
        pass();
        check("idle_sensor_count", bus_if.afisare_locuri, 7);

        // Reset while WAIT_IN at count 7.
        req(1'b1, 1'b0, 8'hA5, {2'b10, 8'd7});
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        m_count = 0;
        check("midrst_count", bus_if.afisare_locuri, 0);
        check("midrst_full", bus_if.parcare_full, 0);
        check("midrst_bariera", bus_if.bariera, 0);
        check("midrst_respins", bus_if.acces_respins, 0);
        check("midrst_state", bus_if.dbg_state, 0);
        pass();
        check("midrst_sensor_count", bus_if.afisare_locuri, 0);

        // Fill to capacity.
        while (m_count < 254) admit();
        check("near_full_flag", bus_if.parcare_full, 0);
        admit();
        check("full_count", bus_if.afisare_locuri, 255);
        check("full_flag", bus_if.parcare_full, 1);
        req(1'b1, 1'b0, 8'hA5, {2'b01, 8'd255});
        check("full_reject_count", bus_if.afisare_locuri, 255);
        leave();
        check("unfull_count", bus_if.afisare_locuri, 254);
        check("unfull_flag", bus_if.parcare_full, 0);

        repeat (5) @(posedge clk);
        check("exp_q_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
